// File: rtl/wavegen_pkg.sv
// Shared waveform codes, default staircase step and the sine-table rounding helper
// used to build the per-channel ROMs at elaboration.
package wavegen_pkg;

  localparam logic [2:0] WAVE_SINE    = 3'd0;
  localparam logic [2:0] WAVE_SQUARE  = 3'd1;
  localparam logic [2:0] WAVE_RAMP_UP = 3'd2;
  localparam logic [2:0] WAVE_RAMP_DN = 3'd3;
  localparam logic [2:0] WAVE_TRI     = 3'd4;
  localparam logic [2:0] WAVE_STAIR   = 3'd5;
  localparam logic [2:0] WAVE_MAX     = 3'd6;

  localparam int QSTEP_DEF = 25;

  // round(MAX*(1+sin(2*pi*k/2^aw))/2), halves round up. Pure integer fixed point
  // (2^30 scale, quadrant folded, Taylor to x^17) so it folds at elaboration; the
  // exact points sin=0/+-1 are special-cased so the .5 ties land correctly.
  function automatic int sine_round(input int k, input int aw, input int ow);
    longint s_one, pi_s, q, quad, j, m, x, term, sum, mx;
    s_one = longint'(1) << 30;
    pi_s  = 64'sd3373259426;
    q     = longint'(1) << (aw - 2);
    quad  = longint'(k) / q;
    j     = longint'(k) % q;
    m     = quad[0] ? q - j : j;
    if (m == 0)      sum = 0;
    else if (m == q) sum = s_one;
    else begin
      x    = (pi_s * m) / (2 * q);
      term = x;
      sum  = x;
      for (int i = 1; i <= 8; i++) begin
        term = -((((term * x) / s_one) * x) / s_one) / longint'((2 * i) * (2 * i + 1));
        sum += term;
      end
    end
    if (quad >= 2) sum = -sum;
    mx = (longint'(1) << ow) - 1;
    return int'((mx * (s_one + sum) + s_one) / (2 * s_one));
  endfunction

endpackage

// File: rtl/wavegen_sine_lut.sv
// Synchronous-read sine ROM, 2^LUT_AW x OUT_W, contents folded at elaboration.
module wavegen_sine_lut
  import wavegen_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-1:0]  q
);

  logic [2**LUT_AW-1:0][OUT_W-1:0] rom;

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic [OUT_W-1:0] V = OUT_W'(sine_round(k, LUT_AW, OUT_W));
    assign rom[k] = V;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= rom[addr];
  end

endmodule

// File: rtl/wavegen_dds.sv
// Multi-channel DDS waveform generator: tick -> accumulators (stage 1) -> waveform
// registers (stage 2). Optional WAVEGEN_QUANT_EN turns code 5 into a quantised triangle.
module wavegen_dds
  import wavegen_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8,
  parameter int LUT_AW  = 8,
  parameter int QSTEP   = QSTEP_DEF,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [2:0]             cfg_wave,
  input  logic [PHASE_W-1:0]     cfg_inc,
  input  logic                   cfg_sync,
  output logic                   out_valid,
  output logic [NCH*OUT_W-1:0]   out_data,
  output logic [NCH-1:0]         phase_wrap
);

  localparam int STAGES = 2;
  localparam logic [OUT_W-1:0] MAX = '1;

  logic [STAGES:0] vld_pipe;
  logic [NCH-1:0]  wrap;
  logic            cfg_fire;

  assign cfg_ready   = !tick;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign vld_pipe[0] = tick;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      phase_wrap         <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      phase_wrap         <= vld_pipe[1] ? wrap : '0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [PHASE_W-1:0] acc, inc;
    logic [2:0]         wave, wave_s2;
    logic               wrap_f, wr;
    logic [OUT_W-1:0]   p, t, tri_v, stair, calc_d, calc_q, lut_q;

    assign wr = cfg_fire && (cfg_ch == CW'(i));

    // Tick and write never share a cycle, so the two updates cannot collide.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc    <= '0;
        inc    <= PHASE_W'(1);
        wave   <= WAVE_SINE;
        wrap_f <= 1'b0;
      end else begin
        if (tick) {wrap_f, acc} <= {1'b0, acc} + {1'b0, inc};
        if (wr) begin
          inc  <= cfg_inc;
          wave <= cfg_wave;
          if (cfg_sync) acc <= '0;
        end
      end
    end

    assign p     = acc[PHASE_W-1 -: OUT_W];
    assign t     = {p[OUT_W-2:0], 1'b0};
    assign tri_v = p[OUT_W-1] ? MAX - t : t;

`ifdef WAVEGEN_QUANT_EN
    logic [31:0] v32, r32, dn32, up32;
    assign v32   = 32'(tri_v);
    assign r32   = v32 % 32'(QSTEP);
    assign dn32  = v32 - r32;
    assign up32  = dn32 + 32'(QSTEP);
    assign stair = (r32 < 32'(QSTEP / 2)) ? OUT_W'(dn32)
                 : (up32 > 32'(MAX))      ? MAX : OUT_W'(up32);
`else
    assign stair = MAX;
`endif

    always_comb begin
      calc_d = MAX;
      case (wave)
        WAVE_SQUARE:  calc_d = p[OUT_W-1] ? '0 : MAX;
        WAVE_RAMP_UP: calc_d = p;
        WAVE_RAMP_DN: calc_d = MAX - p;
        WAVE_TRI:     calc_d = tri_v;
        WAVE_STAIR:   calc_d = stair;
        default:      calc_d = MAX;
      endcase
    end

    // wave_s2 travels with the data so a config write between ticks cannot glitch the mux.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wave_s2 <= WAVE_SINE;
        calc_q  <= '0;
      end else if (vld_pipe[1]) begin
        wave_s2 <= wave;
        calc_q  <= calc_d;
      end
    end

    wavegen_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
      .clk  (clk),
      .rst  (rst),
      .en   (vld_pipe[1]),
      .addr (acc[PHASE_W-1 -: LUT_AW]),
      .q    (lut_q)
    );

    assign out_data[i*OUT_W +: OUT_W] = (wave_s2 == WAVE_SINE) ? lut_q : calc_q;
    assign wrap[i] = wrap_f;
  end

endmodule

// File: tb/tb_wavegen_dds.sv
// Scoreboard bench for wavegen_dds: ticks push expected lanes, a negedge monitor pops on out_valid.
module tb_wavegen_dds;
  localparam int NCH = 3;
  localparam int PW  = 16;
  localparam int OW  = 8;
  localparam int CW  = 2;

  logic              clk = 0, rst = 1, tick = 0;
  logic              cfg_valid = 0, cfg_ready, cfg_sync = 0;
  logic [CW-1:0]     cfg_ch = '0;
  logic [2:0]        cfg_wave = '0;
  logic [PW-1:0]     cfg_inc = '0;
  logic              out_valid;
  logic [NCH*OW-1:0] out_data;
  logic [NCH-1:0]    phase_wrap;

  int tests = 0, fails = 0;

  typedef struct {
    logic [NCH-1:0]         chk;
    logic [NCH-1:0][OW-1:0] d;
    logic [NCH-1:0]         w;
    string                  tag;
  } exp_t;
  exp_t sb[$];

  wavegen_dds #(.NCH(NCH), .PHASE_W(PW), .OUT_W(OW), .LUT_AW(8), .QSTEP(25)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_wave(cfg_wave), .cfg_inc(cfg_inc), .cfg_sync(cfg_sync),
    .out_valid(out_valid), .out_data(out_data), .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int ch, input int d, input bit w, input string tag);
    exp_t e;
    e.chk = '0; e.d = '0; e.w = '0; e.tag = tag;
    e.chk[ch] = 1'b1; e.d[ch] = 8'(d); e.w[ch] = w;
    return e;
  endfunction

  function automatic exp_t add(input exp_t e0, input int ch, input int d, input bit w);
    exp_t e = e0;
    e.chk[ch] = 1'b1; e.d[ch] = 8'(d); e.w[ch] = w;
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick_exp(input exp_t e);
    sb.push_back(e);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int wave, input int inc, input bit sync);
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_wave = 3'(wave); cfg_inc = PW'(inc); cfg_sync = sync;
    step();
    cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got out_valid=1 want no output");
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < NCH; i++) begin
          if (e.chk[i]) begin
            tests++;
            if (out_data[i*OW +: OW] !== e.d[i] || phase_wrap[i] !== e.w[i]) begin
              fails++;
              $display("FAIL %s lane %0d: got data %0d wrap %0b, want data %0d wrap %0b",
                       e.tag, i, out_data[i*OW +: OW], phase_wrap[i], e.d[i], e.w[i]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    step(); step();
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_phase_wrap", 64'(phase_wrap), 64'd0);
    rst = 1'b0;
    step();

    // One tick to get non-zero outputs, then reset with a tick in flight.
    tick_exp(mk(0, 128, 0, "pre_reset_sine"));
    step(); step(); step();
    tick = 1'b1; step(); tick = 1'b0;
    rst = 1'b1; #1;
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_phase_wrap", 64'(phase_wrap), 64'd0);
    step(); step();
    rst = 1'b0;
    step();
    tick_exp(mk(0, 128, 0, "post_reset_sine"));
    step(); step(); step();

    // Ramp up, back-to-back ticks across a full wrap.
    cfg_write(0, 2, 16'h0100, 1);
    for (int k = 1; k <= 256; k++) tick_exp(mk(0, k % 256, k == 256, "ramp"));

    // Square on ch1.
    cfg_write(1, 1, 16'h8000, 1);
    tick_exp(mk(1, 0, 0, "square"));
    tick_exp(mk(1, 255, 1, "square"));
    tick_exp(mk(1, 0, 0, "square"));
    tick_exp(mk(1, 255, 1, "square"));

    // Sine quarter-steps on ch0.
    cfg_write(0, 0, 16'h4000, 1);
    tick_exp(mk(0, 255, 0, "sine_q"));
    tick_exp(mk(0, 128, 0, "sine_q"));
    tick_exp(mk(0, 0, 0, "sine_q"));
    tick_exp(mk(0, 128, 1, "sine_q"));

    // Config held across a tick: stalled that cycle, lands on the next one.
    e = add(mk(1, 0, 0, "held_old"), 0, 255, 0);
    sb.push_back(e);
    tick = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_wave = 3'd2; cfg_inc = 16'h0100; cfg_sync = 1'b0;
    #1 chk("cfg_ready_on_tick", 64'(cfg_ready), 64'd0);
    step();
    tick = 1'b0;
    #1 chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    step();
    cfg_valid = 1'b0;
    tick_exp(add(mk(1, 129, 0, "held_new"), 0, 128, 0));

    // Out-of-range channel: accepted, changes nothing.
    cfg_write(3, 6, 16'h1234, 1);
    tick_exp(add(mk(1, 130, 0, "bad_ch"), 0, 0, 0));

    // Ramp down, triangle and staircase at acc 0x2000 then 0x4000.
    cfg_write(0, 3, 16'h2000, 1);
    cfg_write(1, 4, 16'h2000, 1);
    cfg_write(2, 5, 16'h2000, 1);
`ifdef WAVEGEN_QUANT_EN
    tick_exp(add(add(mk(0, 223, 0, "shapes1"), 1, 64, 0), 2, 75, 0));
    tick_exp(add(add(mk(0, 191, 0, "shapes2"), 1, 128, 0), 2, 125, 0));
`else
    tick_exp(add(add(mk(0, 223, 0, "shapes1"), 1, 64, 0), 2, 255, 0));
    tick_exp(add(add(mk(0, 191, 0, "shapes2"), 1, 128, 0), 2, 255, 0));
`endif

    // inc = 0 freezes the channel but still emits each tick.
    cfg_write(0, 2, 0, 1);
    tick_exp(mk(0, 0, 0, "freeze"));
    tick_exp(mk(0, 0, 0, "freeze"));

    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wavegen_dds.md
# wavegen_dds

Multi-channel, parametrised direct-digital-synthesis waveform generator replacing the single-channel, 8-bit counter-driven generator. Each of NCH channels owns a PHASE_W-bit phase accumulator with a run-time programmable increment and waveform select, and advances once per sample tick. All channel samples are presented together on a packed output bus with a valid strobe. The block feeds the DAC/VGA output path and is configured through a simple valid/ready register-write port.

## Interface
- NCH, 2, number of independent channels (1..8)
- PHASE_W, 16, phase accumulator width (≥ OUT_W+1)
- OUT_W, 8, sample width per channel
- LUT_AW, 8, sine table address width (LUT_AW ≤ PHASE_W)
- QSTEP, 25, staircase quantisation step (only used with WAVEGEN_QUANT_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  sample strobe; advances all accumulators
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_ch  in  max(1,$clog2(NCH))  target channel
- cfg_wave  in  3  waveform code
- cfg_inc  in  PHASE_W  phase increment
- cfg_sync  in  1  clear target accumulator on write
- out_valid  out  1  one-cycle strobe, out_data updated
- out_data  out  NCH*OUT_W  channel i at [i*OUT_W +: OUT_W]
- phase_wrap  out  NCH  per-channel accumulator overflow flag, qualified by out_valid

## Operation
- Per channel registers: acc (reset 0), inc (reset 1), wave (reset 0). Outputs reset: out_data 0, out_valid 0, phase_wrap 0.
- On tick: acc <= (acc + inc) mod 2^PHASE_W; carry-out captured as wrap flag.
- p = acc[PHASE_W-1 -: OUT_W]; MAX = 2^OUT_W-1; t = {p[OUT_W-2:0],1'b0}.
- Wave codes: 0 sine = LUT[acc[PHASE_W-1 -: LUT_AW]], LUT[k] = round(MAX*(1+sin(2πk/2^LUT_AW))/2), .5 rounds up; 1 square = p[MSB]?0:MAX; 2 ramp up = p; 3 ramp down = MAX-p; 4 triangle = p[MSB]?MAX-t:t; 5 staircase (see Configuration); 6,7 constant MAX.
- cfg_ready = !tick. Write accepted when cfg_valid && cfg_ready: inc/wave of cfg_ch loaded at that edge; if cfg_sync, acc of that channel cleared to 0. cfg_ch ≥ NCH: accepted, no effect.
- inc = 0 freezes the channel; output still re-emitted each tick.
- New inc/wave apply from the next tick onward; no glitch on out_data between ticks.

## Timing
- Stage 1 (edge of tick cycle): accumulators and wrap flags update.
- Stage 2 (next edge): waveform values (including synchronous sine LUT read) registered into out_data; out_valid and phase_wrap asserted for exactly that one cycle.
- Latency tick → out_valid: 2 cycles. Back-to-back ticks supported at full rate; each produces one out_valid.
- Tick and config can never coincide (cfg_ready low); a held cfg_valid completes on the first non-tick cycle.
- rst mid-operation: all state to reset values immediately; no out_valid from in-flight ticks.

## Configuration
- WAVEGEN_QUANT_EN defined: code 5 = triangle value v rounded to nearest multiple of QSTEP: r = v mod QSTEP; out = (r < QSTEP/2) ? v-r : min(v-r+QSTEP, MAX). Extra stage-2 combinational logic only; latency unchanged.
- Not defined: code 5 behaves as code 6 (constant MAX); no modulo logic synthesised.

## Structure
- Package wavegen_pkg: waveform code constants (WAVE_SINE..WAVE_MAX), default QSTEP, sine rounding rule helper function.
- Sub-module wavegen_sine_lut: 2^LUT_AW × OUT_W synchronous-read ROM, table generated at elaboration; one instance per channel (or shared read ports, implementer's choice, timing identical).

## Test plan
- Assert rst mid-stream → out_data 0, out_valid 0, phase_wrap 0 same cycle; after release, first tick yields ch0 (sine, inc 1) = LUT[0] = 128 two cycles later.
- ch0 wave 2, inc 0x0100, cfg_sync: tick k → out = k mod 256; tick 256 → out 0 with phase_wrap[0]=1.
- ch1 wave 1, inc 0x8000: ticks give 0, 255, 0, 255; phase_wrap[1] on every even tick.
- ch0 wave 0, inc 0x4000: sequence 255, 128, 0, 128.
- cfg_valid held across tick cycle → cfg_ready 0 that cycle, write lands next cycle; cfg_ch = NCH → no register change.
- WAVEGEN_QUANT_EN, wave 5, acc 0x2000 (t=64) → 75; with macro off → 255.
